seven_seg_scanner: RTL and testbench

Parametrised multiplexed seven-segment display driver for the RAT MCU Basys3 I/O path. It generalises the fixed 4-digit hex driver to N digits and adds per-digit blanking and decimal points, leading-zero suppression, PWM brightness, inter-digit ghost guard, and tear-free frame-synchronous loading through shadow registers. It sits between the MCU output-port registers and the board's cathode/anode pins.

---
 rtl/seven_seg_if.sv | 29 ++
 rtl/seven_seg_scanner.sv | 117 +++++++++++
 tb/tb_seven_seg_scanner.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/seven_seg_if.sv
// Bus between the MCU output-port registers and the seven-segment scanner.
// The master drives digit data and controls; the scanner drives the board pins.
interface seven_seg_if #(
    parameter int NUM_DIGITS  = 4,
    parameter int BRIGHT_BITS = 3
);
    logic [4*NUM_DIGITS-1:0] HEX;
    logic [NUM_DIGITS-1:0]   DP;
    logic [NUM_DIGITS-1:0]   BLANK;
    logic                    LZ_SUPPRESS;
    logic [BRIGHT_BITS-1:0]  BRIGHT;
    logic                    LOAD;
    logic [7:0]              CATHODES;
    logic [NUM_DIGITS-1:0]   ANODES;
    logic                    FRAME_TICK;

    // LOAD is a one-cycle request with no ready: the scanner always accepts it,
    // holds it as pending and captures HEX/DP/BLANK at the next frame boundary
    // (or on the same cycle when LOAD coincides with a boundary).
    modport master (
        output HEX, DP, BLANK, LZ_SUPPRESS, BRIGHT, LOAD,
        input  CATHODES, ANODES, FRAME_TICK
    );

    modport slave (
        input  HEX, DP, BLANK, LZ_SUPPRESS, BRIGHT, LOAD,
        output CATHODES, ANODES, FRAME_TICK
    );
endinterface

// File: rtl/seven_seg_scanner.sv
// N-digit multiplexed seven-segment driver with shadowed frame-synchronous loading,
// blanking, decimal points, leading-zero suppression, PWM brightness and ghost guard.
module seven_seg_scanner #(
    parameter int NUM_DIGITS  = 4,
    parameter int CLK_HZ      = 100_000_000,
    parameter int SCAN_HZ     = 1000,
    parameter int GUARD       = 16,
    parameter int BRIGHT_BITS = 3
) (
    input logic       CLK,
    input logic       RST_N,
    seven_seg_if.slave bus
);
    localparam int DIV = CLK_HZ / SCAN_HZ;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CW-1:0] DWELL_LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] GUARD_END  = CW'(GUARD);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    function automatic logic [6:0] font(input logic [3:0] n);
        case (n)
            4'h0:    font = 7'b0000001;
            4'h1:    font = 7'b1001111;
            4'h2:    font = 7'b0010010;
            4'h3:    font = 7'b0000110;
            4'h4:    font = 7'b1001100;
            4'h5:    font = 7'b0100100;
            4'h6:    font = 7'b0100000;
            4'h7:    font = 7'b0001111;
            4'h8:    font = 7'b0000000;
            4'h9:    font = 7'b0000100;
            4'hA:    font = 7'b0001000;
            4'hB:    font = 7'b1100000;
            4'hC:    font = 7'b0110001;
            4'hD:    font = 7'b1000010;
            4'hE:    font = 7'b0110000;
            default: font = 7'b0111000;
        endcase
    endfunction

    logic [CW-1:0]           dwell_q, dwell_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [BRIGHT_BITS-1:0]  pwm_q, pwm_d;
    logic                    pending_q, pending_d;
    logic [4*NUM_DIGITS-1:0] sh_hex_q, sh_hex_d;
    logic [NUM_DIGITS-1:0]   sh_dp_q, sh_dp_d;
    logic [NUM_DIGITS-1:0]   sh_blank_q, sh_blank_d;
    logic [7:0]              cathodes_q, cathodes_d;
    logic [NUM_DIGITS-1:0]   anodes_q, anodes_d;
    logic                    frame_tick_q;

    logic                    wrap, boundary, capture, run, dark;
    logic [NUM_DIGITS-1:0]   sup;
    logic [3:0]              nib;

    // Outputs are computed from the next-state values so that the pins track
    // the counters in the same cycle the counters hold them.
    always_comb begin
        wrap       = (dwell_q == DWELL_LAST);
        boundary   = wrap && (idx_q == IDX_LAST);
        capture    = boundary && (pending_q || bus.LOAD);
        dwell_d    = wrap ? '0 : dwell_q + 1'b1;
        idx_d      = idx_q;
        if (wrap) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        pwm_d      = pwm_q + 1'b1;
        pending_d  = capture ? 1'b0 : (pending_q | bus.LOAD);
        sh_hex_d   = capture ? bus.HEX   : sh_hex_q;
        sh_dp_d    = capture ? bus.DP    : sh_dp_q;
        sh_blank_d = capture ? bus.BLANK : sh_blank_q;

        // Zeros above the highest non-zero nibble go dark; digit 0 never does.
        sup = '0;
        run = bus.LZ_SUPPRESS;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            run    = run & (sh_hex_d[4*i +: 4] == 4'h0);
            sup[i] = run;
        end

        nib        = sh_hex_d[{idx_d, 2'b00} +: 4];
        dark       = sh_blank_d[idx_d] | sup[idx_d];
        cathodes_d = dark ? 8'hFF : {~sh_dp_d[idx_d], font(nib)};
        anodes_d   = '1;
        if (!dark && (dwell_d >= GUARD_END) && (pwm_d <= bus.BRIGHT))
            anodes_d[idx_d] = 1'b0;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            dwell_q      <= '0;
            idx_q        <= '0;
            pwm_q        <= '0;
            pending_q    <= 1'b0;
            sh_hex_q     <= '0;
            sh_dp_q      <= '0;
            sh_blank_q   <= '1;
            cathodes_q   <= 8'hFF;
            anodes_q     <= '1;
            frame_tick_q <= 1'b0;
        end else begin
            dwell_q      <= dwell_d;
            idx_q        <= idx_d;
            pwm_q        <= pwm_d;
            pending_q    <= pending_d;
            sh_hex_q     <= sh_hex_d;
            sh_dp_q      <= sh_dp_d;
            sh_blank_q   <= sh_blank_d;
            cathodes_q   <= cathodes_d;
            anodes_q     <= anodes_d;
            frame_tick_q <= boundary;
        end
    end

    assign bus.CATHODES   = cathodes_q;
    assign bus.ANODES     = anodes_q;
    assign bus.FRAME_TICK = frame_tick_q;
endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench for seven_seg_scanner: a frame-level reference model checked
// every cycle, plus hand-computed digit patterns, latencies and duty counts.
module tb_seven_seg_scanner;
    localparam int N     = 4;
    localparam int DIV   = 10;
    localparam int GUARD = 2;
    localparam int FRAME = N * DIV;

    logic CLK;
    logic RST_N;
    int   n_checks = 0;
    int   n_errors = 0;

    seven_seg_if #(.NUM_DIGITS(N), .BRIGHT_BITS(3)) bus ();

    seven_seg_scanner #(
        .NUM_DIGITS(N), .CLK_HZ(1000), .SCAN_HZ(100), .GUARD(GUARD), .BRIGHT_BITS(3)
    ) dut (
        .CLK(CLK),
        .RST_N(RST_N),
        .bus(bus)
    );

    // ---------------- clock ----------------
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // ---------------- reference model ----------------
    logic [6:0] font_tab [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                  7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                  7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                                  7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
    int         k, m_pos, m_idx, m_dw, m_p, m_hi;
    logic       m_pending, m_bnd, m_dark;
    logic [15:0] m_hex;
    logic [3:0] m_dp, m_blank;
    logic [7:0] exp_cat  = 8'hFF;
    logic [3:0] exp_an   = 4'hF;
    logic       exp_tick = 1'b0;

    // k = clock edges since reset release; everything follows from k and the shown frame.
    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            k = 0; m_pending = 1'b0;
            m_hex = '0; m_dp = '0; m_blank = 4'hF;
            exp_cat = 8'hFF; exp_an = 4'hF; exp_tick = 1'b0;
        end else begin
            k     = k + 1;
            m_bnd = (k % FRAME) == 0;
            if (m_bnd && (m_pending || bus.LOAD)) begin
                m_hex = bus.HEX; m_dp = bus.DP; m_blank = bus.BLANK; m_pending = 1'b0;
            end else if (bus.LOAD) begin
                m_pending = 1'b1;
            end
            m_pos = k % FRAME;
            m_idx = m_pos / DIV;
            m_dw  = m_pos % DIV;
            m_p   = k % 8;
            m_hi  = -1;
            for (int i = 0; i < N; i++) if (m_hex[4*i +: 4] != 4'h0) m_hi = i;
            m_dark  = m_blank[m_idx] || (bus.LZ_SUPPRESS && m_idx > m_hi && m_idx != 0);
            exp_cat = m_dark ? 8'hFF : {~m_dp[m_idx], font_tab[m_hex[4*m_idx +: 4]]};
            exp_an  = 4'hF;
            if (!m_dark && m_dw >= GUARD && m_p <= int'(bus.BRIGHT)) exp_an[m_idx] = 1'b0;
            exp_tick = m_bnd;
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        chk("model_cathodes", bus.CATHODES, exp_cat);
        chk("model_anodes", bus.ANODES, exp_an);
        chk("model_frame_tick", bus.FRAME_TICK, exp_tick);
    end

    // ---------------- driver tasks ----------------
    task automatic do_load(input logic [15:0] hex, input logic [3:0] dp, input logic [3:0] blank);
        bus.HEX = hex; bus.DP = dp; bus.BLANK = blank; bus.LOAD = 1'b1;
        @(negedge CLK);
        bus.LOAD = 1'b0;
    endtask

    task automatic wait_tick(input int limit, input string name);
        int i;
        i = 0;
        while (!bus.FRAME_TICK && i < limit) begin
            @(negedge CLK);
            i++;
        end
        n_checks++;
        if (!bus.FRAME_TICK) begin
            n_errors++;
            $display("FAIL %s: FRAME_TICK got 0 expected 1 within %0d clocks", name, limit);
        end
    endtask

    // Starts on the FRAME_TICK cycle (digit 0, dwell 0), ends on the last cycle of the frame.
    task automatic walk_frame(input string name, input logic [31:0] cats,
                              input logic [3:0] lit, input int lows);
        int cnt [N];
        int d, c;
        logic [3:0] an_on;
        for (int i = 0; i < N; i++) cnt[i] = 0;
        for (int pos = 0; pos < FRAME; pos++) begin
            if (pos > 0) @(negedge CLK);
            d     = pos / DIV;
            c     = pos % DIV;
            an_on = 4'hF ^ (4'(1) << d);
            if (c == 1) chk({name, "_guard"}, bus.ANODES, 4'hF);
            if (c == 5) chk({name, "_cathodes"}, bus.CATHODES, cats[8*d +: 8]);
            if (c >= GUARD && bus.ANODES == an_on) cnt[d]++;
        end
        for (int i = 0; i < N; i++) chk({name, "_on_count"}, cnt[i], lit[i] ? lows : 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        RST_N = 1'b1;
        bus.HEX = '0; bus.DP = '0; bus.BLANK = '0; bus.LZ_SUPPRESS = 1'b0;
        bus.BRIGHT = 3'd7; bus.LOAD = 1'b0;
        #1 RST_N = 1'b0;
        repeat (3) @(negedge CLK);
        chk("reset_cathodes", bus.CATHODES, 8'hFF);
        chk("reset_anodes", bus.ANODES, 4'hF);
        chk("reset_tick", bus.FRAME_TICK, 1'b0);
        RST_N = 1'b1;

        // First load after reset, full-brightness frame of 12AF.
        do_load(16'h12AF, 4'b0000, 4'b0000);
        wait_tick(40, "first_tick");
        walk_frame("hex_12af", {8'b11001111, 8'b10010010, 8'b10001000, 8'b10111000}, 4'hF, 8);

        // Leading-zero suppression, loaded on the boundary cycle.
        bus.LZ_SUPPRESS = 1'b1;
        do_load(16'h0040, 4'b0000, 4'b0000);
        wait_tick(1, "lz_tick");
        walk_frame("lz_0040", {8'hFF, 8'hFF, 8'b11001100, 8'b10000001}, 4'b0011, 8);
        do_load(16'h0000, 4'b0000, 4'b0000);
        walk_frame("lz_0000", {8'hFF, 8'hFF, 8'hFF, 8'b10000001}, 4'b0001, 8);

        // PWM duty.
        bus.LZ_SUPPRESS = 1'b0;
        bus.BRIGHT = 3'd3;
        do_load(16'h12AF, 4'b0000, 4'b0000);
        walk_frame("bright3", {8'b11001111, 8'b10010010, 8'b10001000, 8'b10111000}, 4'hF, 4);
        bus.BRIGHT = 3'd0;
        wait_tick(2, "bright0_tick");
        walk_frame("bright0", {8'b11001111, 8'b10010010, 8'b10001000, 8'b10111000}, 4'hF, 1);
        bus.BRIGHT = 3'd7;

        // Mid-frame load must not tear the current frame.
        wait_tick(2, "pre_mid_tick");
        repeat (15) @(negedge CLK);
        do_load(16'h3456, 4'b0000, 4'b0000);
        repeat (9) @(negedge CLK);
        chk("mid_digit2_old", bus.CATHODES, 8'b10010010);
        repeat (10) @(negedge CLK);
        chk("mid_digit3_old", bus.CATHODES, 8'b11001111);
        wait_tick(6, "mid_tick");
        walk_frame("hex_3456", {8'b10000110, 8'b11001100, 8'b10100100, 8'b10100000}, 4'hF, 8);

        // Load on the boundary cycle appears one clock later.
        do_load(16'h789A, 4'b0000, 4'b0000);
        chk("bnd_load_tick", bus.FRAME_TICK, 1'b1);
        chk("bnd_load_digit0", bus.CATHODES, 8'b10001000);
        walk_frame("hex_789a", {8'b10001111, 8'b10000000, 8'b10000100, 8'b10001000}, 4'hF, 8);

        // Decimal point and blanking.
        do_load(16'h12AF, 4'b0100, 4'b0001);
        walk_frame("dp_blank", {8'b11001111, 8'b00010010, 8'b10001000, 8'hFF}, 4'b1110, 8);

        // Asynchronous reset in the middle of a lit dwell.
        repeat (15) @(negedge CLK);
        chk("pre_reset_anodes", bus.ANODES, 4'b1101);
        @(posedge CLK);
        #3 RST_N = 1'b0;
        #1;
        chk("async_rst_cathodes", bus.CATHODES, 8'hFF);
        chk("async_rst_anodes", bus.ANODES, 4'hF);
        chk("async_rst_tick", bus.FRAME_TICK, 1'b0);
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        repeat (2 * FRAME + 5) @(negedge CLK);
        chk("dark_after_rst_cathodes", bus.CATHODES, 8'hFF);
        chk("dark_after_rst_anodes", bus.ANODES, 4'hF);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
